// File: rtl/rvc_asap_5pl_cr_master.sv
// CR memory initiator: issues core loads/stores as registered CR strobes and
// returns read data in order through a credit-limited response FIFO.
module rvc_asap_5pl_cr_master #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic [31:0] cr_address_o,
   output logic [31:0] cr_data_o,
   output logic        cr_wren_o,
   output logic        cr_rden_o,
   input  logic [31:0] cr_q_i,
   output logic        busy_o
);

   localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
   localparam int unsigned AW = $clog2(RSP_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
   localparam logic [CW-1:0] LAST_C  = CW'(RSP_DEPTH - 1);

   logic [CW-1:0] inflight_q, inflight_d;
   logic          accept, rd_accept, fifo_push, fifo_pop;

   logic          cr_wren_q, cr_rden_q;
   logic [31:0]   cr_address_q, cr_data_q;
   logic [RD_LATENCY-1:0] lat_q;

   logic [31:0]   fifo_mem_q [RSP_DEPTH];
   logic [CW-1:0] wr_ptr_q, rd_ptr_q, fifo_count_q;

   function automatic logic [CW-1:0] incPtr(input logic [CW-1:0] p);
      return (p == LAST_C) ? '0 : p + CW'(1);
   endfunction

   // Credits cover every read from accept until its response is popped, so
   // the FIFO can never be pushed while full.
   assign req_ready_o = (inflight_q < DEPTH_C);
   assign accept      = req_valid_i & req_ready_o;
   assign rd_accept   = accept & ~req_wr_i;
   assign fifo_push   = lat_q[RD_LATENCY-1];
   assign rsp_valid_o = (fifo_count_q != '0);
   assign fifo_pop    = rsp_valid_o & rsp_ready_i;

   always_comb begin
      inflight_d = inflight_q;
      case ({rd_accept, fifo_pop})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inflight_q   <= '0;
         cr_wren_q    <= 1'b0;
         cr_rden_q    <= 1'b0;
         cr_address_q <= '0;
         cr_data_q    <= '0;
         lat_q        <= '0;
      end else begin
         inflight_q <= inflight_d;
         cr_wren_q  <= accept & req_wr_i;
         cr_rden_q  <= rd_accept;
         if (accept) begin
            cr_address_q <= req_addr_i;
            cr_data_q    <= req_wr_i ? req_wdata_i : '0;
         end
         lat_q[0] <= cr_rden_q;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            lat_q[i] <= lat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(RSP_DEPTH); i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= cr_q_i;
            wr_ptr_q <= incPtr(wr_ptr_q);
         end
         if (fifo_pop) begin
            rd_ptr_q <= incPtr(rd_ptr_q);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
            2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   assign rsp_rdata_o  = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign cr_address_o = cr_address_q;
   assign cr_data_o    = cr_data_q;
   assign cr_wren_o    = cr_wren_q;
   assign cr_rden_o    = cr_rden_q;
   assign busy_o       = (inflight_q != '0);

endmodule

// File: tb/tb_rvc_asap_5pl_cr_master.sv
// Directed bench for the CR master with a registered CR memory model
// (one-cycle read latency, switch register at a fixed offset).
module tb_rvc_asap_5pl_cr_master;

   localparam int RD_LATENCY = 1;
   localparam int RSP_DEPTH  = 4;
   localparam logic [31:0] CR_SEG7_0 = 32'h0000_0000;
   localparam logic [31:0] CR_LED    = 32'h0000_0018;
   localparam logic [31:0] CR_SWITCH = 32'h0000_001C;

   logic        clk, rst;
   logic        reqValid, reqReady, reqWr;
   logic [31:0] reqAddr, reqWdata;
   logic        rspValid, rspReady;
   logic [31:0] rspRdata;
   logic [31:0] crAddress, crData, crQ;
   logic        crWren, crRden, busy;

   logic [31:0] crMem [16];
   logic [31:0] switchVal;

   int checkCount = 0;
   int failCount  = 0;

   rvc_asap_5pl_cr_master #(.RD_LATENCY(RD_LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(reqValid), .req_ready_o(reqReady), .req_wr_i(reqWr),
      .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
      .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata),
      .cr_address_o(crAddress), .cr_data_o(crData),
      .cr_wren_o(crWren), .cr_rden_o(crRden), .cr_q_i(crQ), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CR memory model: registered q, switch register is read-only.
   initial crQ = '0;
   always @(posedge clk) begin
      if (crWren) crMem[crAddress[5:2]] <= crData;
      if (crRden) crQ <= (crAddress == CR_SWITCH) ? switchVal : crMem[crAddress[5:2]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Whenever the FIFO is full, nothing may be pushed into it.
   always @(negedge clk) begin
      if (!rst && dut.fifo_count_q == RSP_DEPTH) checkOutput("push_full", 32'(dut.fifo_push), 32'd0);
   end

   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      int waitCycles = 0;
      reqValid = 1'b1; reqWr = wr; reqAddr = addr; reqWdata = wdata;
      @(negedge clk);
      while (!reqReady && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!reqReady) checkOutput("req_timeout", 32'(reqReady), 32'd1);
      @(posedge clk); #1;
      reqValid = 1'b0;
   endtask

   initial begin
      #200000;
      failCount++;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   initial begin
      int accepted, extra, stray;
      for (int i = 0; i < 16; i++) crMem[i] = '0;
      rst = 1'b1; reqValid = 0; reqWr = 0; reqAddr = '0; reqWdata = '0;
      rspReady = 0; switchVal = 32'h0000_02A5;
      #2;
      checkOutput("rst_wren", 32'(crWren), 0);
      checkOutput("rst_rden", 32'(crRden), 0);
      checkOutput("rst_addr", crAddress, 0);
      checkOutput("rst_data", crData, 0);
      checkOutput("rst_rspvalid", 32'(rspValid), 0);
      checkOutput("rst_rdata", rspRdata, 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_ready", 32'(reqReady), 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] single write to SEG7_0");
      applyStimulus(1'b1, CR_SEG7_0, 32'h0000_003F);
      @(negedge clk);
      checkOutput("wr_wren", 32'(crWren), 1);
      checkOutput("wr_rden", 32'(crRden), 0);
      checkOutput("wr_addr", crAddress, CR_SEG7_0);
      checkOutput("wr_data", crData, 32'h3F);
      checkOutput("wr_rspvalid", 32'(rspValid), 0);
      checkOutput("wr_busy", 32'(busy), 0);
      @(negedge clk);
      checkOutput("wr_wren_drop", 32'(crWren), 0);
      checkOutput("wr_rspvalid2", 32'(rspValid), 0);
      checkOutput("wr_busy2", 32'(busy), 0);
      @(posedge clk); #1;

      $display("[TB] write LED then read it back");
      rspReady = 1'b1;
      applyStimulus(1'b1, CR_LED, 32'h0000_0155);
      applyStimulus(1'b0, CR_LED, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("rd_rden", 32'(crRden), 1);
      checkOutput("rd_wren", 32'(crWren), 0);
      checkOutput("rd_addr", crAddress, CR_LED);
      checkOutput("rd_data_zero", crData, 0);
      checkOutput("rd_busy", 32'(busy), 1);
      checkOutput("rd_lat1", 32'(rspValid), 0);
      @(negedge clk);
      checkOutput("rd_lat2", 32'(rspValid), 0);
      @(negedge clk);
      checkOutput("rd_lat3", 32'(rspValid), 1);
      checkOutput("rd_value", rspRdata, 32'h155);
      @(negedge clk);
      checkOutput("rd_after", 32'(rspValid), 0);
      checkOutput("rd_busy_end", 32'(busy), 0);
      @(posedge clk); #1;

      $display("[TB] eight back-to-back switch reads");
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               reqValid = 1'b1; reqWr = 1'b0; reqAddr = CR_SWITCH;
               @(negedge clk);
               checkOutput("b2b_ready", 32'(reqReady), 1);
               @(posedge clk); #1;
            end
            reqValid = 1'b0;
         end
         begin
            int w = 0;
            @(negedge clk);
            while (!rspValid && w < 20) begin
               @(negedge clk);
               w++;
            end
            for (int k = 0; k < 8; k++) begin
               if (k > 0) @(negedge clk);
               checkOutput("b2b_valid", 32'(rspValid), 1);
               checkOutput("b2b_data", rspRdata, 32'h2A5);
            end
            @(negedge clk);
            checkOutput("b2b_end", 32'(rspValid), 0);
         end
      join
      @(posedge clk); #1;

      $display("[TB] credit exhaustion with stalled consumer");
      rspReady = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(4 * i), 32'(8'hA0 + i));
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         reqValid = 1'b1; reqWr = 1'b0; reqAddr = 32'(4 * i);
         @(negedge clk);
         if (reqReady) accepted++;
         @(posedge clk); #1;
      end
      reqValid = 1'b0;
      checkOutput("credit_accepts", 32'(accepted), 4);
      rspReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("drain_valid", 32'(rspValid), 1);
         checkOutput("drain_data", rspRdata, 32'(8'hA0 + k));
         if (k == 0) begin
            checkOutput("credit_ready_low", 32'(reqReady), 0);
            checkOutput("credit_busy", 32'(busy), 1);
         end
         if (k == 1) checkOutput("ready_reassert", 32'(reqReady), 1);
      end
      @(negedge clk);
      checkOutput("drain_empty", 32'(rspValid), 0);
      checkOutput("drain_busy", 32'(busy), 0);
      @(posedge clk); #1;

      $display("[TB] interleaved SEG7 reads with random backpressure");
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(4 * i), 32'(i + 1));
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               int gap;
               applyStimulus(1'b0, 32'(4 * i), 32'h0);
               gap = int'($urandom_range(0, 2));
               for (int g = 0; g < gap; g++) begin
                  @(posedge clk); #1;
               end
            end
         end
         begin
            int got = 0;
            int cyc = 0;
            while (got < 6 && cyc < 200) begin
               @(posedge clk); #1;
               rspReady = 1'($urandom_range(0, 1));
               @(negedge clk);
               if (rspValid && rspReady) begin
                  checkOutput("order_data", rspRdata, 32'(got + 1));
                  got++;
               end
               cyc++;
            end
            checkOutput("order_count", 32'(got), 6);
         end
      join
      @(posedge clk); #1;
      rspReady = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rspValid) extra++;
      end
      checkOutput("order_no_extra", 32'(extra), 0);
      checkOutput("order_busy", 32'(busy), 0);
      @(posedge clk); #1;

      $display("[TB] reset with reads in flight");
      rspReady = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, CR_SWITCH, 32'h0);
      reqValid = 1'b1; reqWr = 1'b0; reqAddr = CR_SWITCH;
      #2;
      rst = 1'b1;
      reqValid = 1'b0;
      #1;
      checkOutput("mid_rst_wren", 32'(crWren), 0);
      checkOutput("mid_rst_rden", 32'(crRden), 0);
      checkOutput("mid_rst_addr", crAddress, 0);
      checkOutput("mid_rst_rspvalid", 32'(rspValid), 0);
      checkOutput("mid_rst_rdata", rspRdata, 0);
      checkOutput("mid_rst_busy", 32'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rspValid || crRden || crWren) stray++;
      end
      checkOutput("post_rst_quiet", 32'(stray), 0);
      @(posedge clk); #1;
      rspReady = 1'b1;
      applyStimulus(1'b0, CR_SWITCH, 32'h0);
      @(negedge clk);
      checkOutput("post_rst_lat1", 32'(rspValid), 0);
      @(negedge clk);
      checkOutput("post_rst_lat2", 32'(rspValid), 0);
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(rspValid), 1);
      checkOutput("post_rst_data", rspRdata, 32'h2A5);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
